mem_arbiter: RTL and testbench

Two-port arbiter that shares the core's single memory port between the instruction-fetch requester and the load/store (data) requester. It sits between the pipeline and the memory (later the cache). It grants one request at a time, tracks the single outstanding transaction, and routes each response back to its owner. It also discards instruction responses invalidated by a pipeline flush.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory port between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority, data over instruction.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn_i,
    input  logic                flush_i,

    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_gnt_o,
    output logic                i_rvalid_o,
    output logic [DATA_W-1:0]   i_rdata_o,

    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,

    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t state_q, state_d;
    logic   owner_d_q, owner_d_n;   // 1: outstanding transaction belongs to the data port
    logic   drop_q, drop_n;

    logic   issue_ok;
    logic   pick_d;
    logic   pick_i;
    logic   grant;
    logic   resp;

`ifdef MEM_ARB_RR_EN
    logic   fav_i_q;                // 1: instruction port wins a tie

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            fav_i_q <= 1'b1;
        end else if (grant) begin
            fav_i_q <= pick_d;
        end
    end

    assign pick_d = d_req_i && (!i_req_i || !fav_i_q);
`else
    assign pick_d = d_req_i;
`endif

    assign pick_i    = i_req_i && !pick_d;
    assign i_rdata_o = mem_rdata_i;
    assign d_rdata_o = mem_rdata_i;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            owner_d_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_d_q <= owner_d_n;
            drop_q    <= drop_n;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d_n   = owner_d_q;
        drop_n      = drop_q;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        i_gnt_o     = 1'b0;
        d_gnt_o     = 1'b0;
        i_rvalid_o  = 1'b0;
        d_rvalid_o  = 1'b0;

        // A slot is free when idle, or when the outstanding response returns this cycle.
        issue_ok = rstn_i && ((state_q == ST_IDLE) || mem_rvalid_i);
        resp     = (state_q == ST_WAIT) && mem_rvalid_i;

        if (issue_ok && pick_d) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (issue_ok && pick_i) begin
            mem_en_o    = 1'b1;
            mem_be_o    = '1;
            mem_addr_o  = i_addr_i;
        end

        grant   = mem_en_o && mem_ready_i;
        d_gnt_o = grant && pick_d;
        i_gnt_o = grant && pick_i;

        if (resp) begin
            d_rvalid_o = owner_d_q;
            i_rvalid_o = !owner_d_q && !drop_q && !flush_i;
        end

        if (grant) begin
            state_d   = ST_WAIT;
            owner_d_n = pick_d;
            drop_n    = pick_i && flush_i;
        end else if (resp) begin
            state_d   = ST_IDLE;
            drop_n    = 1'b0;
        end else if ((state_q == ST_WAIT) && !owner_d_q && flush_i) begin
            drop_n    = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          flush_i;
    logic          i_req_i;
    logic [AW-1:0] i_addr_i;
    logic          i_gnt_o;
    logic          i_rvalid_o;
    logic [DW-1:0] i_rdata_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [3:0]    d_be_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_gnt_o;
    logic          d_rvalid_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ready_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rstn_i(rstn_i), .flush_i(flush_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
        .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        flush_i = 0; i_req_i = 0; i_addr_i = '0; d_req_i = 0; d_we_i = 0; d_be_i = '0;
        d_addr_i = '0; d_wdata_i = '0; mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    // transaction-level model state
    bit       o_busy, o_d, o_drop;
    bit       m_pend;
    int       m_cnt;
    bit       i_hold, d_hold;
    bit       e_issue, e_win_d, e_win_i, e_gnt, e_en;
`ifdef MEM_ARB_RR_EN
    bit       fav_i;
`endif
    bit       exp_d_seq [4];

    initial begin
        quiet();
        rstn_i = 0;

        // reset: everything quiet even with requests pending
        cyc();
        i_req_i = 1; d_req_i = 1; mem_ready_i = 1; i_addr_i = 32'h40;
        #4;
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_i_gnt", i_gnt_o, 0);
        chk("rst_d_gnt", d_gnt_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        cyc(); quiet(); rstn_i = 1;

        // lone instruction read
        cyc(); i_req_i = 1; i_addr_i = 32'h100; mem_ready_i = 1;
        #4;
        chk("ird_gnt", i_gnt_o, 1);
        chk("ird_en", mem_en_o, 1);
        chk("ird_addr", mem_addr_o, 32'h100);
        chk("ird_be", mem_be_o, 4'hF);
        chk("ird_we", mem_we_o, 0);
        chk("ird_d_gnt", d_gnt_o, 0);
        cyc(); quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        #4;
        chk("ird_rvalid", i_rvalid_o, 1);
        chk("ird_rdata", i_rdata_o, 32'hDEADBEEF);
        chk("ird_d_rvalid", d_rvalid_o, 0);
        cyc(); quiet();

        // data write
        d_req_i = 1; d_we_i = 1; d_be_i = 4'h3; d_addr_i = 32'h2000; d_wdata_i = 32'h1234;
        mem_ready_i = 1;
        #4;
        chk("dwr_gnt", d_gnt_o, 1);
        chk("dwr_we", mem_we_o, 1);
        chk("dwr_be", mem_be_o, 4'h3);
        chk("dwr_addr", mem_addr_o, 32'h2000);
        chk("dwr_wdata", mem_wdata_o, 32'h1234);
        cyc(); quiet(); mem_rvalid_i = 1;
        #4;
        chk("dwr_ack", d_rvalid_o, 1);
        chk("dwr_i_rvalid", i_rvalid_o, 0);
        cyc(); quiet();

        // memory backpressure for 3 cycles
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc();
            i_req_i = 1; i_addr_i = 32'h200; mem_ready_i = 0;
            #4;
            chk("bp_en", mem_en_o, 1);
            chk("bp_gnt", i_gnt_o, 0);
        end
        cyc(); mem_ready_i = 1;
        #4;
        chk("bp_gnt4", i_gnt_o, 1);
        cyc(); quiet(); mem_rvalid_i = 1;
        #4;
        chk("bp_rvalid", i_rvalid_o, 1);
        cyc(); quiet();

        // flush during an outstanding instruction read, 3-cycle memory
        i_req_i = 1; i_addr_i = 32'h300; mem_ready_i = 1;
        #4;
        chk("fl_gnt", i_gnt_o, 1);
        cyc(); quiet(); flush_i = 1;
        cyc(); quiet();
        cyc(); quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
        i_req_i = 1; i_addr_i = 32'h304; mem_ready_i = 1;
        #4;
        chk("fl_rvalid", i_rvalid_o, 0);
        chk("fl_regnt", i_gnt_o, 1);
        cyc(); quiet(); mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        #4;
        chk("fl_next_rvalid", i_rvalid_o, 1);
        chk("fl_next_rdata", i_rdata_o, 32'h55);
        cyc(); quiet();

        // both ports requesting with a 1-cycle memory; last grant went to I
`ifdef MEM_ARB_RR_EN
        exp_d_seq = '{1, 0, 1, 0};
`else
        exp_d_seq = '{1, 1, 1, 1};
`endif
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            i_req_i = 1; i_addr_i = 32'h400; d_req_i = 1; d_addr_i = 32'h3000;
            mem_ready_i = 1; mem_rvalid_i = (k > 0);
            #4;
            chk("both_d_gnt", d_gnt_o, exp_d_seq[k]);
            chk("both_i_gnt", i_gnt_o, !exp_d_seq[k]);
        end
        cyc(); d_req_i = 0; mem_rvalid_i = 1;
        #4;
        chk("both_i_after", i_gnt_o, 1);
        cyc(); quiet(); mem_rvalid_i = 1;
        cyc(); quiet();

        // reset mid-transaction
        i_req_i = 1; i_addr_i = 32'h500; mem_ready_i = 1;
        #4;
        chk("mrst_gnt", i_gnt_o, 1);
        cyc(); d_req_i = 1; d_addr_i = 32'h600; mem_rvalid_i = 1; rstn_i = 0;
        #4;
        chk("mrst_en", mem_en_o, 0);
        chk("mrst_i_gnt", i_gnt_o, 0);
        chk("mrst_d_gnt", d_gnt_o, 0);
        chk("mrst_i_rvalid", i_rvalid_o, 0);
        chk("mrst_d_rvalid", d_rvalid_o, 0);
        chk("mrst_fields", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 0);
        cyc(); quiet(); rstn_i = 1; mem_rvalid_i = 1;
        #4;
        chk("stray_i_rvalid", i_rvalid_o, 0);
        chk("stray_d_rvalid", d_rvalid_o, 0);
        cyc(); quiet();

        // randomized traffic against the transaction model (block is idle, pointer favours I)
        o_busy = 0; o_d = 0; o_drop = 0; m_pend = 0; m_cnt = 0; i_hold = 0; d_hold = 0;
`ifdef MEM_ARB_RR_EN
        fav_i = 1;
`endif
        for (int c = 0; c < 3000; c++) begin
            cyc();
            mem_rvalid_i = m_pend && (m_cnt == 1);
            mem_rdata_i  = $urandom;
            if (!i_hold) begin
                i_req_i  = ($urandom_range(0, 99) < 45);
                i_addr_i = $urandom;
            end
            if (!d_hold) begin
                d_req_i   = ($urandom_range(0, 99) < 45);
                d_we_i    = $urandom_range(0, 1);
                d_be_i    = 4'($urandom);
                d_addr_i  = $urandom;
                d_wdata_i = $urandom;
            end
            flush_i     = ($urandom_range(0, 9) == 0);
            mem_ready_i = ($urandom_range(0, 3) != 0);
            #4;

            e_issue = !o_busy || mem_rvalid_i;
            e_win_d = 0;
            e_win_i = 0;
            if (e_issue) begin
                if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
                    e_win_d = !fav_i;
`else
                    e_win_d = 1;
`endif
                    e_win_i = !e_win_d;
                end else begin
                    e_win_d = d_req_i;
                    e_win_i = i_req_i;
                end
            end
            e_en  = e_win_d || e_win_i;
            e_gnt = e_en && mem_ready_i;

            chk("r_mem_en", mem_en_o, e_en);
            chk("r_d_gnt", d_gnt_o, e_gnt && e_win_d);
            chk("r_i_gnt", i_gnt_o, e_gnt && e_win_i);
            if (e_win_d) begin
                chk("r_d_fields", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                    {d_we_i, d_be_i, d_addr_i, d_wdata_i});
            end else if (e_win_i) begin
                chk("r_i_fields", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                    {1'b0, 4'hF, i_addr_i, 32'h0});
            end else begin
                chk("r_idle_fields", {mem_we_o, mem_be_o, mem_wdata_o}, 0);
            end
            chk("r_d_rvalid", d_rvalid_o, o_busy && mem_rvalid_i && o_d);
            chk("r_i_rvalid", i_rvalid_o, o_busy && mem_rvalid_i && !o_d && !o_drop && !flush_i);
            if (o_busy && mem_rvalid_i) begin
                chk("r_rdata", o_d ? d_rdata_o : i_rdata_o, mem_rdata_i);
            end

            if (o_busy && !o_d && flush_i) o_drop = 1;
            if (o_busy && mem_rvalid_i) o_busy = 0;
            if (mem_rvalid_i) m_pend = 0;
            else if (m_pend) m_cnt--;
            if (e_gnt) begin
                o_busy = 1;
                o_d    = e_win_d;
                o_drop = e_win_i && flush_i;
                m_pend = 1;
                m_cnt  = $urandom_range(1, 3);
`ifdef MEM_ARB_RR_EN
                fav_i  = e_win_d;
`endif
            end
            i_hold = i_req_i && !(e_gnt && e_win_i);
            d_hold = d_req_i && !(e_gnt && e_win_d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
